tail_light_monitor: RTL
=======================

// Module: tail_light_monitor
// PURPOSE
//  Receive-side checker/decoder for the 6-bit tail-light pattern bus driven by the turn-signal FSM.
//  Samples lights[5:0] (left lamps [5:3], right lamps [2:0]) and reconstructs the active direction and sweep phase.
//  Counts completed sweeps and flags illegal codes or illegal code-to-code transitions.
//  Sits on the display side of the lamp interface, for on-board self-check and bench scoreboarding.
// PARAMETERS
//  CNT_W   8   width of the saturating completed-sweep counter
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      synchronous, active-low (reset==0 clears on next rising clk)
//  sample_en   in   1      1: sample lights this cycle; 0: hold all state, err forced 0
//  lights      in   6      pattern under observation
//  dir         out  2      00 idle, 01 left, 10 right (11 unused)
//  phase       out  2      lamps lit in the sweep: 1..3; 0 in gap or idle
//  sweep_cnt   out  CNT_W  completed sweeps (legal L2->L3 or R2->R3), saturates at all-ones
//  err         out  1      one-cycle pulse: illegal code or illegal transition sampled
//  err_sticky  out  1      set by any err, cleared only by reset
// BEHAVIOUR
//  - All outputs registered. Reset values: dir=00, phase=0, sweep_cnt=0, err=0, err_sticky=0, state=IDLE.
//  - Latency: a sample taken at edge N is reflected on the outputs after edge N (one-cycle pipeline).
//  - Legal codes: 000000 ZERO, 001000 L1, 011000 L2, 111000 L3, 000100 R1, 000110 R2, 000111 R3. Any other code is illegal.
//  - States: IDLE, L1, L2, L3, LGAP, R1, R2, R3, RGAP.
//  - Legal transitions, next sample shown in parentheses:
//    IDLE: ZERO->IDLE, L1->L1, R1->R1
//    L1: L2->L2. L2: L3->L3. L3: ZERO->LGAP. LGAP: L1->L1, ZERO->IDLE
//    R1: R2->R2. R2: R3->R3. R3: ZERO->RGAP. RGAP: R1->R1, ZERO->IDLE
//    Any L1..L3 or LGAP state: R1->R1 (direction change) and ZERO->IDLE (abort) are legal,
//      except that ZERO from L3 goes to LGAP, as listed above.
//    Any R1..R3 or RGAP state: L1->L1 and ZERO->IDLE are legal,
//      except that ZERO from R3 goes to RGAP, as listed above.
//  - Illegal transition with a legal code: err=1 and err_sticky=1.
//    The monitor resyncs to the state implied by the code (L3 code -> L3, ZERO -> IDLE).
//  - Illegal code: err=1, err_sticky=1, state -> IDLE.
//  - Output decode:
//    dir = 01 for L1..L3 and LGAP; 10 for R1..R3 and RGAP; 00 for IDLE.
//    phase = index for L1..L3 / R1..R3, else 0.
//  - sweep_cnt increments only on a legal L2->L3 or R2->R3. Resync into L3/R3 never counts. At all-ones it holds.
//  - sample_en=0: state, dir, phase, sweep_cnt and err_sticky hold; err=0.
//  - Reset has priority over sample_en. A reset asserted mid-sweep clears everything on that edge.
// STRUCTURE
//  - Shared package tail_light_pkg holds:
//    the 7 legal pattern constants (shared with the FSM driver), the 9-state monitor encoding,
//    the dir encoding, and a 3-bit code-class enum (ZERO, L1..L3, R1..R3, ILLEGAL).
//  - One combinational sub-module, tail_light_pattern_decode: lights[5:0] -> code class.
//  - The top level holds the state register, transition check, counter, and err logic.
// TESTING
//  1 reset=0 for 2 clks with random lights -> dir=00, phase=0, sweep_cnt=0, err=0, err_sticky=0.
//  2 left sweep 001000,011000,111000,000000,001000 -> dir=01 throughout; phase 1,2,3,0,1; sweep_cnt=1 after 111000; err never 1.
//  3 000100,000110,001000,000000,000000 -> dir 10,10,01,00,00; phase 1,2,1,0,0; no err; sweep_cnt=0.
//  4 lights=101000 from IDLE -> err=1 for exactly one cycle; err_sticky=1 and stays 1; dir=00.
//  5 001000 then 111000 -> err pulse; resync to L3 (dir=01, phase=3); sweep_cnt unchanged.
//  6 CNT_W=2, five full right sweeps -> sweep_cnt reads 1,2,3,3,3.
//    Then sample_en=0 with lights toggling -> all outputs frozen, err=0.
//    Then reset=0 mid-sweep -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/tail_light_pkg.sv
// Shared encodings for the tail-light lamp bus: legal lamp patterns, decoded
// code classes, monitor states and direction values.
package tail_light_pkg;

  localparam logic [5:0] PAT_ZERO = 6'b000000;
  localparam logic [5:0] PAT_L1   = 6'b001000;
  localparam logic [5:0] PAT_L2   = 6'b011000;
  localparam logic [5:0] PAT_L3   = 6'b111000;
  localparam logic [5:0] PAT_R1   = 6'b000100;
  localparam logic [5:0] PAT_R2   = 6'b000110;
  localparam logic [5:0] PAT_R3   = 6'b000111;

  typedef enum logic [2:0] {
    CODE_ZERO, CODE_L1, CODE_L2, CODE_L3,
    CODE_R1, CODE_R2, CODE_R3, CODE_ILLEGAL
  } code_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_L1, ST_L2, ST_L3, ST_LGAP,
    ST_R1, ST_R2, ST_R3, ST_RGAP
  } mon_state_e;

  typedef enum logic [1:0] {
    DIR_IDLE  = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_RIGHT = 2'b10
  } dir_e;

  // State the monitor lands in when it has to trust the code alone
  function automatic mon_state_e state_of_code(input code_e c);
    case (c)
      CODE_L1: return ST_L1;
      CODE_L2: return ST_L2;
      CODE_L3: return ST_L3;
      CODE_R1: return ST_R1;
      CODE_R2: return ST_R2;
      CODE_R3: return ST_R3;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tail_light_pattern_decode.sv
// Classifies a raw 6-bit lamp pattern into one of the legal codes or ILLEGAL.
module tail_light_pattern_decode
  import tail_light_pkg::*;
(
  input  logic [5:0] lights_i,
  output code_e      code_o
);

  always_comb begin
    case (lights_i)
      PAT_ZERO: code_o = CODE_ZERO;
      PAT_L1:   code_o = CODE_L1;
      PAT_L2:   code_o = CODE_L2;
      PAT_L3:   code_o = CODE_L3;
      PAT_R1:   code_o = CODE_R1;
      PAT_R2:   code_o = CODE_R2;
      PAT_R3:   code_o = CODE_R3;
      default:  code_o = CODE_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/tail_light_monitor.sv
// Receive-side monitor for the tail-light bus: tracks sweep direction/phase,
// counts completed sweeps and flags illegal codes or transitions.
module tail_light_monitor
  import tail_light_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [5:0]       lights,
  output logic [1:0]       dir,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] sweep_cnt,
  output logic             err,
  output logic             err_sticky
);

  code_e            code;
  mon_state_e       state_q, state_d;
  logic             legal, count_en;
  logic [1:0]       dir_q, dir_d, phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, sticky_q, sticky_d;

  tail_light_pattern_decode u_decode (
    .lights_i (lights),
    .code_o   (code)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_IDLE;
      phase_q  <= 2'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  // On an illegal step we still follow the code so the monitor resyncs at once
  always_comb begin
    state_d  = state_q;
    legal    = 1'b0;
    count_en = 1'b0;
    if (sample_en) begin
      state_d = state_of_code(code);
      case (code)
        CODE_ZERO: begin
          legal = 1'b1;
          if (state_q == ST_L3)      state_d = ST_LGAP;
          else if (state_q == ST_R3) state_d = ST_RGAP;
        end
        CODE_L1: legal = state_q inside {ST_IDLE, ST_LGAP, ST_R1, ST_R2, ST_R3, ST_RGAP};
        CODE_L2: legal = (state_q == ST_L1);
        CODE_L3: begin
          legal    = (state_q == ST_L2);
          count_en = legal;
        end
        CODE_R1: legal = state_q inside {ST_IDLE, ST_RGAP, ST_L1, ST_L2, ST_L3, ST_LGAP};
        CODE_R2: legal = (state_q == ST_R1);
        CODE_R3: begin
          legal    = (state_q == ST_R2);
          count_en = legal;
        end
        default: legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    dir_d   = DIR_IDLE;
    phase_d = 2'd0;
    case (state_d)
      ST_L1:   begin dir_d = DIR_LEFT;  phase_d = 2'd1; end
      ST_L2:   begin dir_d = DIR_LEFT;  phase_d = 2'd2; end
      ST_L3:   begin dir_d = DIR_LEFT;  phase_d = 2'd3; end
      ST_LGAP: dir_d = DIR_LEFT;
      ST_R1:   begin dir_d = DIR_RIGHT; phase_d = 2'd1; end
      ST_R2:   begin dir_d = DIR_RIGHT; phase_d = 2'd2; end
      ST_R3:   begin dir_d = DIR_RIGHT; phase_d = 2'd3; end
      ST_RGAP: dir_d = DIR_RIGHT;
      default: dir_d = DIR_IDLE;
    endcase
    err_d    = sample_en & ~legal;
    sticky_d = sticky_q | err_d;
    cnt_d    = (count_en && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  assign dir        = dir_q;
  assign phase      = phase_q;
  assign sweep_cnt  = cnt_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;

endmodule
